mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares a single-ported unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the 3-stage MIPS pipeline. It serialises accesses through a small FSM, registers the memory-side command, and returns read data with a one-cycle valid pulse. It also drives the pipeline-wide stall that freezes PC, pipeline registers and the register-file write while an access is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; the byte mask is DATA_W/8 bits
STARVE_LIMIT, 4, number of consecutive I-pending cycles after which I wins over D

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held with i_addr until i_valid
i_addr  in  ADDR_W  fetch address
i_valid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held with fields until d_valid
d_we  in  1  1=store, 0=load
d_mask  in  DATA_W/8  store byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_valid  out  1  one-cycle pulse: load data valid or store done
d_rdata  out  DATA_W  load data
mem_req  out  1  memory command valid
mem_we  out  1  memory write enable
mem_mask  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepted command this cycle
mem_rvalid  in  1  read data valid; at least one cycle after gnt
mem_rdata  in  DATA_W  memory read data
stall  out  1  pipeline freeze

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; owner=I; starvation counter=0; all outputs 0, including the data buses.
- States:
  - IDLE: arbitrate.
  - CMD: mem_req=1 until mem_gnt.
  - RESP: wait for mem_rvalid.
  - DONE: pulse the valid for one cycle.
- IDLE arbitration, over eligible requesters only:
  - A requester is ineligible during the cycle its own valid is pulsing.
  - D wins by default.
  - I wins if only I is pending, or if the counter equals STARVE_LIMIT.
  - Winner's fields are latched into registered mem_* and the owner register; next state is CMD.
- Latched command fields:
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Reads: mem_we=0, mem_mask=all ones, mem_wdata=0.
  - Stores: d_we, d_mask and d_wdata are latched as given.
- CMD:
  - Command fields hold stable while mem_gnt=0.
  - On mem_gnt: mem_req drops next cycle.
  - Store: go to DONE.
  - Read: go to RESP.
- RESP: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to DONE. mem_rvalid in any other state is ignored.
- DONE:
  - The owner's valid=1 for exactly this cycle.
  - The rdata register holds its value until the next capture by the same owner.
  - Arbitration (IDLE rules) is evaluated in the same cycle, so back-to-back accesses start with no idle bubble.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle where i_req=1 and owner≠I or state=IDLE-without-I-grant.
  - Clears when I is granted.
- Latency, best case (gnt in the first CMD cycle, rvalid the next cycle):
  - Read: req sampled at cycle 0, mem_req at 1, rvalid at 2, valid at 3.
  - Store: d_valid at cycle 2.
- stall = (i_req & ~i_valid) | (d_req & ~d_valid), combinational. It is low in any cycle where every active requester's valid is pulsing.
- Requester drops req before its grant: the request is abandoned and no valid is produced. After its grant: the access completes and valid still pulses.
- Simultaneous i_req and d_req with counter<STARVE_LIMIT: D first, then I back-to-back.
- Reset asserted mid-transaction: return to IDLE immediately; no valid is produced. The memory side tolerates the abandoned command.

Test Plan:
- Reset: reset=0 with requests active -> all outputs 0; release -> first grant 1 cycle after a request.
- Single fetch: i_req, i_addr=0x0000_0013, gnt immediate, rvalid next cycle with 0x2408_0005 -> mem_addr=0x0000_0010, mem_we=0, mem_mask=4'hF; i_valid pulse at cycle 3, i_rdata=0x2408_0005; stall high cycles 0-2, low at 3.
- Store: d_we=1, d_mask=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF, gnt delayed 3 cycles -> mem_* held stable for 4 CMD cycles; d_valid exactly one pulse, the cycle after gnt.
- Contention: i_req and d_req together, both held -> D served first; I granted in D's DONE cycle; no duplicate D access.
- Starvation, STARVE_LIMIT=4: I pending while D re-requests continuously -> I granted at the first arbitration after the counter hits 4; counter returns to 0.
- Reset mid-RESP: reset=0 in the cycle before rvalid -> state IDLE, no i_valid; a late rvalid after release is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch (I) and load/store (D) requesters onto one memory port.
// Uses a 4-state FSM. The memory command is registered, and each access ends with a one-cycle valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [MASK_W-1:0]   mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic i_elig, d_elig, arb_en, grant_i, grant_d;
  logic unused_addr_bits;

  // The memory is word addressed; the low address bits carry no information for it.
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign i_valid   = (state_q == S_DONE) && (owner_q == OWN_I);
  assign d_valid   = (state_q == S_DONE) && (owner_q == OWN_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_mask  = mem_mask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stall is held low while reset is asserted, so that every output reads zero during reset.
  assign stall = reset & ((i_req & ~i_valid) | (d_req & ~d_valid));

  // A requester whose valid is pulsing has just been served and cannot win again in that cycle.
  always_comb begin
    i_elig  = i_req & ~i_valid;
    d_elig  = d_req & ~d_valid;
    arb_en  = (state_q == S_IDLE) || (state_q == S_DONE);
    grant_i = arb_en & i_elig & (~d_elig | (starve_q == CNT_MAX));
    grant_d = arb_en & d_elig & ~grant_i;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_mask_d  = mem_mask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE, S_DONE: state_d = S_IDLE;
      S_CMD: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? S_DONE : S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_D) d_rdata_d = mem_rdata;
          else                  i_rdata_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_i || grant_d) begin
      state_d   = S_CMD;
      owner_d   = grant_d ? OWN_D : OWN_I;
      mem_req_d = 1'b1;
      if (grant_d) begin
        mem_addr_d = {d_addr[ADDR_W-1:2], 2'b00};
      end else begin
        mem_addr_d = {i_addr[ADDR_W-1:2], 2'b00};
      end
      if (grant_d && d_we) begin
        mem_we_d    = 1'b1;
        mem_mask_d  = d_mask;
        mem_wdata_d = d_wdata;
      end else begin
        mem_we_d    = 1'b0;
        mem_mask_d  = '1;
        mem_wdata_d = '0;
      end
    end

    // I is counted as waiting while D owns the port or while arbitration passes it over.
    if (grant_i) begin
      starve_d = '0;
    end else if (i_req && ((state_q == S_IDLE) || (owner_q == OWN_D))) begin
      if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_mask_q  <= mem_mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// It drives per-cycle vectors from a table, then runs hand-written starvation and reset-abort sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_mask;
  logic        i_valid, d_valid, mem_req, mem_we, stall;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  typedef struct {
    logic        rst_n, ireq, dreq, dwe, gnt, rv;
    logic [31:0] iaddr, daddr, dwdata, rdata;
    logic [3:0]  dmask;
    logic        e_ival, e_dval, e_stall, e_mreq, e_mwe;
    logic [3:0]  e_mmask;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dd,
    input logic g, input logic rv, input logic [31:0] rd,
    input logic eiv, input logic edv, input logic est, input logic emr, input logic emw,
    input logic [3:0] emm, input logic [31:0] ema, input logic [31:0] emd,
    input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.rst_n = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.dmask = dm;
    v.daddr = da; v.dwdata = dd; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.e_ival = eiv; v.e_dval = edv; v.e_stall = est; v.e_mreq = emr; v.e_mwe = emw;
    v.e_mmask = emm; v.e_maddr = ema; v.e_mwdata = emd; v.e_irdata = eir; v.e_drdata = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_i(input logic r, input logic [31:0] a);
    i_req = r; i_addr = a;
  endtask

  task automatic set_d(input logic r, input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
    d_req = r; d_we = w; d_mask = m; d_addr = a; d_wdata = wd;
  endtask

  task automatic set_m(input logic g, input logic rv, input logic [31:0] rd);
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0);

    // Columns: rst ireq iaddr | dreq dwe dmask daddr dwdata | gnt rv rdata || ival dval stall mreq mwe mmask maddr mwdata irdata drdata
    // Reset with requests active, then a single fetch of 0x13.
    vecs.push_back(mk(0,1,32'h13, 1,1,4'h3,32'h100,32'hDEADBEEF, 0,0,32'h0,        0,0,0,0,0,4'h0,32'h0,  32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(1,1,32'h13, 0,0,4'h0,32'h0,  32'h0,        0,0,32'h0,        0,0,1,0,0,4'h0,32'h0,  32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(1,1,32'h13, 0,0,4'h0,32'h0,  32'h0,        1,0,32'h0,        0,0,1,1,0,4'hF,32'h10, 32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(1,1,32'h13, 0,0,4'h0,32'h0,  32'h0,        0,1,32'h24080005, 0,0,1,0,0,4'hF,32'h10, 32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(1,1,32'h13, 0,0,4'h0,32'h0,  32'h0,        0,0,32'h0,        1,0,0,0,0,4'hF,32'h10, 32'h0,        32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  0,0,4'h0,32'h0,  32'h0,        0,0,32'h0,        0,0,0,0,0,4'hF,32'h10, 32'h0,        32'h24080005, 32'h0));
    // Store with grant delayed three cycles; an rvalid during CMD must be ignored.
    vecs.push_back(mk(1,0,32'h0,  1,1,4'h3,32'h100,32'hDEADBEEF, 0,0,32'h0,        0,0,1,0,0,4'hF,32'h10, 32'h0,        32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  1,1,4'h3,32'h100,32'hDEADBEEF, 0,0,32'h0,        0,0,1,1,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  1,1,4'h3,32'h100,32'hDEADBEEF, 0,1,32'hBAD0BAD0, 0,0,1,1,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  1,1,4'h3,32'h100,32'hDEADBEEF, 0,0,32'h0,        0,0,1,1,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  1,1,4'h3,32'h100,32'hDEADBEEF, 1,0,32'h0,        0,0,1,1,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  1,1,4'h3,32'h100,32'hDEADBEEF, 0,0,32'h0,        0,1,0,0,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    vecs.push_back(mk(1,0,32'h0,  0,0,4'h0,32'h0,  32'h0,        0,0,32'h0,        0,0,0,0,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    // Contention: both loads together, D first, I granted in D's DONE cycle.
    vecs.push_back(mk(1,1,32'h204,1,0,4'h0,32'h302,32'h55,       0,0,32'h0,        0,0,1,0,1,4'h3,32'h100,32'hDEADBEEF, 32'h24080005, 32'h0));
    vecs.push_back(mk(1,1,32'h204,1,0,4'h0,32'h302,32'h55,       1,0,32'h0,        0,0,1,1,0,4'hF,32'h300,32'h0,        32'h24080005, 32'h0));
    vecs.push_back(mk(1,1,32'h204,1,0,4'h0,32'h302,32'h55,       0,1,32'h11112222, 0,0,1,0,0,4'hF,32'h300,32'h0,        32'h24080005, 32'h0));
    vecs.push_back(mk(1,1,32'h204,1,0,4'h0,32'h302,32'h55,       0,0,32'h0,        0,1,1,0,0,4'hF,32'h300,32'h0,        32'h24080005, 32'h11112222));
    vecs.push_back(mk(1,1,32'h204,0,0,4'h0,32'h0,  32'h0,        1,0,32'h0,        0,0,1,1,0,4'hF,32'h204,32'h0,        32'h24080005, 32'h11112222));
    vecs.push_back(mk(1,1,32'h204,0,0,4'h0,32'h0,  32'h0,        0,1,32'h33334444, 0,0,1,0,0,4'hF,32'h204,32'h0,        32'h24080005, 32'h11112222));
    vecs.push_back(mk(1,1,32'h204,0,0,4'h0,32'h0,  32'h0,        0,0,32'h0,        1,0,0,0,0,4'hF,32'h204,32'h0,        32'h33334444, 32'h11112222));
    vecs.push_back(mk(1,0,32'h0,  0,0,4'h0,32'h0,  32'h0,        0,0,32'h0,        0,0,0,0,0,4'hF,32'h204,32'h0,        32'h33334444, 32'h11112222));

    for (int k = 0; k < vecs.size(); k++) begin
      next_cycle();
      reset = vecs[k].rst_n;
      set_i(vecs[k].ireq, vecs[k].iaddr);
      set_d(vecs[k].dreq, vecs[k].dwe, vecs[k].dmask, vecs[k].daddr, vecs[k].dwdata);
      set_m(vecs[k].gnt, vecs[k].rv, vecs[k].rdata);
      #3;
      $display("vec %0d: ival=%b dval=%b stall=%b mreq=%b maddr=%h", k, i_valid, d_valid, stall, mem_req, mem_addr);
      chk($sformatf("v%0d i_valid", k),   32'(i_valid),   32'(vecs[k].e_ival));
      chk($sformatf("v%0d d_valid", k),   32'(d_valid),   32'(vecs[k].e_dval));
      chk($sformatf("v%0d stall", k),     32'(stall),     32'(vecs[k].e_stall));
      chk($sformatf("v%0d mem_req", k),   32'(mem_req),   32'(vecs[k].e_mreq));
      chk($sformatf("v%0d mem_we", k),    32'(mem_we),    32'(vecs[k].e_mwe));
      chk($sformatf("v%0d mem_mask", k),  32'(mem_mask),  32'(vecs[k].e_mmask));
      chk($sformatf("v%0d mem_addr", k),  mem_addr,       vecs[k].e_maddr);
      chk($sformatf("v%0d mem_wdata", k), mem_wdata,      vecs[k].e_mwdata);
      chk($sformatf("v%0d i_rdata", k),   i_rdata,        vecs[k].e_irdata);
      chk($sformatf("v%0d d_rdata", k),   d_rdata,        vecs[k].e_drdata);
    end

    // Starvation: I waits through a slow D load, so the counter saturates at 4.
    next_cycle(); set_i(1, 32'h500); set_d(1, 0, 4'h0, 32'h400, 32'h0); set_m(0, 0, 32'h0); #3;
    $display("starve: D load issued with I pending");
    chk("starve d_first_stall", 32'(stall), 32'd1);
    next_cycle(); #3; chk("starve d_cmd_addr", mem_addr, 32'h400);
    next_cycle(); #3;
    next_cycle(); set_m(1, 0, 32'h0); #3; chk("starve d_cmd_req", 32'(mem_req), 32'd1);
    next_cycle(); set_m(0, 1, 32'hAAAA5555); #3; chk("starve d_resp_req", 32'(mem_req), 32'd0);
    next_cycle(); set_i(0, 32'h0); set_m(0, 0, 32'h0); #3;
    $display("starve: D done, I withdraws");
    chk("starve d_valid", 32'(d_valid), 32'd1);
    chk("starve d_rdata", d_rdata, 32'hAAAA5555);
    // With the counter saturated, I must beat D when both arrive together.
    next_cycle(); set_i(1, 32'h500); set_d(1, 0, 4'h0, 32'h600, 32'h0); #3;
    chk("starve idle_req", 32'(mem_req), 32'd0);
    next_cycle(); set_m(1, 0, 32'h0); #3;
    $display("starve: both pending, addr=%h", mem_addr);
    chk("starve i_wins_addr", mem_addr, 32'h500);
    chk("starve i_wins_we", 32'(mem_we), 32'd0);
    next_cycle(); set_m(0, 1, 32'h12345678); #3;
    next_cycle(); set_m(0, 0, 32'h0); #3;
    chk("starve i_valid", 32'(i_valid), 32'd1);
    chk("starve i_rdata", i_rdata, 32'h12345678);
    chk("starve stall_d_waiting", 32'(stall), 32'd1);
    next_cycle(); set_i(0, 32'h0); set_m(1, 0, 32'h0); #3;
    chk("starve d_b2b_addr", mem_addr, 32'h600);
    chk("starve d_b2b_req", 32'(mem_req), 32'd1);
    next_cycle(); set_m(0, 1, 32'h0F0F0F0F); #3;
    next_cycle(); set_m(0, 0, 32'h0); #3;
    chk("starve d_valid2", 32'(d_valid), 32'd1);
    chk("starve d_rdata2", d_rdata, 32'h0F0F0F0F);
    next_cycle(); set_d(0, 0, 4'h0, 32'h0, 32'h0); #3;
    chk("starve idle_after", 32'(mem_req), 32'd0);
    // The counter has cleared, so D wins a tie again.
    next_cycle(); set_i(1, 32'h800); set_d(1, 0, 4'h0, 32'h900, 32'h0); #3;
    next_cycle(); set_m(1, 0, 32'h0); #3;
    $display("starve: counter cleared, addr=%h", mem_addr);
    chk("starve d_wins_again", mem_addr, 32'h900);

    // Reset lands in RESP before rvalid; a late rvalid after release must be ignored.
    next_cycle(); set_m(0, 0, 32'h0); #3;
    chk("rst resp_state_req", 32'(mem_req), 32'd0);
    next_cycle(); reset = 1'b0; set_i(0, 32'h0); set_d(0, 0, 4'h0, 32'h0, 32'h0); #3;
    $display("reset: asserted mid-RESP");
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_mask", 32'(mem_mask), 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    chk("rst i_rdata", i_rdata, 32'h0);
    chk("rst d_valid", 32'(d_valid), 32'd0);
    next_cycle(); reset = 1'b1; set_m(0, 1, 32'hCAFEF00D); #3;
    next_cycle(); set_m(0, 0, 32'h0); #3;
    $display("reset: late rvalid ignored, dval=%b drdata=%h", d_valid, d_rdata);
    chk("rst late_dval", 32'(d_valid), 32'd0);
    chk("rst late_ival", 32'(i_valid), 32'd0);
    chk("rst late_drdata", d_rdata, 32'h0);
    chk("rst late_mreq", 32'(mem_req), 32'd0);
    set_d(1, 1, 4'hF, 32'hA03, 32'h1);
    next_cycle(); #3;
    $display("reset: fresh store after recovery, addr=%h", mem_addr);
    chk("rst regrant_req", 32'(mem_req), 32'd1);
    chk("rst regrant_addr", mem_addr, 32'hA00);
    chk("rst regrant_we", 32'(mem_we), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
